// File: rtl/perf_counter_bank_if.sv
// Control, read and overflow signals of one performance counter bank.
// The master side is software/monitor logic; the slave side is the bank itself.
interface perf_counter_bank_if #(
  parameter int unsigned CH_NUM    = 8,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned IDX_WIDTH = 3
) ();
  logic [CH_NUM-1:0]    inc;
  logic                 freeze;
  logic                 clr_all;
  logic                 wr_en;
  logic [IDX_WIDTH-1:0] wr_idx;
  logic [CNT_WIDTH-1:0] wr_data;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 rd_ovf;
  logic [CH_NUM-1:0]    ovf;

  modport master (
    output inc, freeze, clr_all, wr_en, wr_idx, wr_data, rd_idx,
    input  rd_data, rd_ovf, ovf
  );

  modport slave (
    input  inc, freeze, clr_all, wr_en, wr_idx, wr_data, rd_idx,
    output rd_data, rd_ovf, ovf
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of independent event counters with sticky overflow flags,
// single-channel write/clear, clear-all, global freeze and a registered read port.
module perf_counter_bank #(
  parameter int unsigned CH_NUM    = 8,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned IDX_WIDTH = 3,
  parameter int unsigned SATURATE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  perf_counter_bank_if.slave bus
);

  logic [CNT_WIDTH-1:0] cnt_q [CH_NUM];
  logic [CNT_WIDTH-1:0] cnt_d [CH_NUM];
  logic [CH_NUM-1:0]    of_q;
  logic [CH_NUM-1:0]    of_d;
  logic [CNT_WIDTH-1:0] rd_data_q;
  logic [CNT_WIDTH-1:0] rd_data_d;
  logic                 rd_ovf_q;
  logic                 rd_ovf_d;

  // Priority per channel: clr_all, then write, then freeze, then increment.
  always_comb begin
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      of_d[i]  = of_q[i];
      if (bus.clr_all) begin
        cnt_d[i] = '0;
        of_d[i]  = 1'b0;
      end else if (bus.wr_en && (32'(bus.wr_idx) == i)) begin
        cnt_d[i] = bus.wr_data;
        of_d[i]  = 1'b0;
      end else if (!bus.freeze && bus.inc[i]) begin
        if (&cnt_q[i]) begin
          of_d[i]  = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Out-of-range read index matches no channel and so returns zero.
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (32'(bus.rd_idx) == i) begin
        rd_data_d = cnt_q[i];
        rd_ovf_d  = of_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '{default: '0};
      of_q      <= '0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      of_q      <= of_d;
      rd_data_q <= rd_data_d;
      rd_ovf_q  <= rd_ovf_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_ovf  = rd_ovf_q;
  assign bus.ovf     = of_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed checks of perf_counter_bank in three configurations:
// default (8x32 wrap), 6x4 wrap and 8x4 saturating.
module tb_perf_counter_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  perf_counter_bank_if #(.CH_NUM(8), .CNT_WIDTH(32), .IDX_WIDTH(3)) ba ();
  perf_counter_bank_if #(.CH_NUM(6), .CNT_WIDTH(4),  .IDX_WIDTH(3)) bn ();
  perf_counter_bank_if #(.CH_NUM(8), .CNT_WIDTH(4),  .IDX_WIDTH(3)) bs ();

  perf_counter_bank #(.CH_NUM(8), .CNT_WIDTH(32), .IDX_WIDTH(3), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ba));
  perf_counter_bank #(.CH_NUM(6), .CNT_WIDTH(4), .IDX_WIDTH(3), .SATURATE(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bn));
  perf_counter_bank #(.CH_NUM(8), .CNT_WIDTH(4), .IDX_WIDTH(3), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .bus(bs));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ba.inc = '0; ba.freeze = 1'b0; ba.clr_all = 1'b0; ba.wr_en = 1'b0;
    ba.wr_idx = '0; ba.wr_data = '0; ba.rd_idx = '0;
    bn.inc = '0; bn.freeze = 1'b0; bn.clr_all = 1'b0; bn.wr_en = 1'b0;
    bn.wr_idx = '0; bn.wr_data = '0; bn.rd_idx = '0;
    bs.inc = '0; bs.freeze = 1'b0; bs.clr_all = 1'b0; bs.wr_en = 1'b0;
    bs.wr_idx = '0; bs.wr_data = '0; bs.rd_idx = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (ba.rd_data !== 32'd0 || ba.rd_ovf !== 1'b0 || ba.ovf !== 8'h00) begin
      errors++;
      $display("FAIL reset_a rd_data=%0h rd_ovf=%0b ovf=%0h expected 0 0 0",
               ba.rd_data, ba.rd_ovf, ba.ovf);
    end
    checks++;
    if (bn.ovf !== 6'h00 || bs.ovf !== 8'h00 || bn.rd_data !== 4'h0 || bs.rd_data !== 4'h0) begin
      errors++;
      $display("FAIL reset_ns bn.ovf=%0h bs.ovf=%0h bn.rd=%0h bs.rd=%0h expected 0",
               bn.ovf, bs.ovf, bn.rd_data, bs.rd_data);
    end
  endtask

  task automatic test_count();
    ba.inc = 8'b0000_0101;
    ba.rd_idx = 3'd0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (ba.rd_data !== 32'(k - 1)) begin
        errors++;
        $display("FAIL count_ramp step %0d rd_data=%0d expected %0d", k, ba.rd_data, k - 1);
      end
    end
    ba.inc = '0;
    step();
    checks++;
    if (ba.rd_data !== 32'd10) begin
      errors++;
      $display("FAIL count_ch0 rd_data=%0d expected 10", ba.rd_data);
    end
    ba.rd_idx = 3'd1;
    step();
    checks++;
    if (ba.rd_data !== 32'd0) begin
      errors++;
      $display("FAIL count_ch1 rd_data=%0d expected 0", ba.rd_data);
    end
    ba.rd_idx = 3'd2;
    step();
    checks++;
    if (ba.rd_data !== 32'd10) begin
      errors++;
      $display("FAIL count_ch2 rd_data=%0d expected 10", ba.rd_data);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_rd [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
    logic       exp_ro [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_of [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bn.wr_en = 1'b1; bn.wr_idx = 3'd3; bn.wr_data = 4'hE; bn.rd_idx = 3'd3;
    step();
    bn.wr_en = 1'b0;
    checks++;
    if (bn.ovf !== 6'h00) begin
      errors++;
      $display("FAIL wrap_preload ovf=%0h expected 0", bn.ovf);
    end
    for (int k = 0; k < 4; k++) begin
      bn.inc = (k < 3) ? 6'b001000 : 6'b000000;
      step();
      checks++;
      if (bn.rd_data !== exp_rd[k] || bn.rd_ovf !== exp_ro[k] || bn.ovf[3] !== exp_of[k]) begin
        errors++;
        $display("FAIL wrap_step %0d rd_data=%0h rd_ovf=%0b ovf3=%0b expected %0h %0b %0b",
                 k, bn.rd_data, bn.rd_ovf, bn.ovf[3], exp_rd[k], exp_ro[k], exp_of[k]);
      end
    end
  endtask

  task automatic test_saturate();
    bs.wr_en = 1'b1; bs.wr_idx = 3'd3; bs.wr_data = 4'hF; bs.rd_idx = 3'd3;
    step();
    bs.wr_en = 1'b0;
    bs.inc = 8'b0000_1000;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bs.ovf !== 8'h08) begin
        errors++;
        $display("FAIL sat_ovf step %0d ovf=%0h expected 08", k, bs.ovf);
      end
    end
    bs.inc = '0;
    step();
    checks++;
    if (bs.rd_data !== 4'hF || bs.rd_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold rd_data=%0h rd_ovf=%0b expected F 1", bs.rd_data, bs.rd_ovf);
    end
    bs.wr_en = 1'b1; bs.wr_data = 4'h0;
    step();
    bs.wr_en = 1'b0;
    checks++;
    if (bs.ovf !== 8'h00) begin
      errors++;
      $display("FAIL sat_clr_ovf ovf=%0h expected 0", bs.ovf);
    end
    step();
    checks++;
    if (bs.rd_data !== 4'h0 || bs.rd_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr_read rd_data=%0h rd_ovf=%0b expected 0 0", bs.rd_data, bs.rd_ovf);
    end
  endtask

  task automatic test_collision();
    ba.clr_all = 1'b1;
    step();
    ba.clr_all = 1'b0;
    ba.wr_en = 1'b1; ba.wr_idx = 3'd2; ba.wr_data = 32'd100; ba.inc = 8'hFF;
    step();
    ba.freeze = 1'b1; ba.wr_idx = 3'd5; ba.wr_data = 32'd55;
    step();
    ba.freeze = 1'b0; ba.wr_en = 1'b0; ba.inc = '0;
    for (int c = 0; c < 8; c++) begin
      logic [31:0] exp;
      exp = (c == 2) ? 32'd100 : (c == 5) ? 32'd55 : 32'd1;
      ba.rd_idx = 3'(c);
      step();
      checks++;
      if (ba.rd_data !== exp) begin
        errors++;
        $display("FAIL collision ch%0d rd_data=%0d expected %0d", c, ba.rd_data, exp);
      end
    end
  endtask

  task automatic test_clr_all();
    bn.clr_all = 1'b1; bn.wr_en = 1'b1; bn.wr_idx = 3'd3; bn.wr_data = 4'h9; bn.inc = 6'h3F;
    step();
    bn.clr_all = 1'b0; bn.inc = '0;
    checks++;
    if (bn.ovf !== 6'h00) begin
      errors++;
      $display("FAIL clr_all_ovf ovf=%0h expected 0", bn.ovf);
    end
    bn.wr_idx = 3'd7; bn.wr_data = 4'h5; bn.inc = 6'b000001;
    step();
    bn.wr_en = 1'b0; bn.inc = '0;
    checks++;
    if (bn.ovf !== 6'h00) begin
      errors++;
      $display("FAIL oor_write_ovf ovf=%0h expected 0", bn.ovf);
    end
    for (int c = 1; c <= 6; c++) begin
      logic [3:0] exp;
      exp = (c == 6) ? 4'h1 : 4'h0;
      bn.rd_idx = (c == 6) ? 3'd0 : 3'(c);
      step();
      checks++;
      if (bn.rd_data !== exp) begin
        errors++;
        $display("FAIL clr_all_read idx%0d rd_data=%0h expected %0h", bn.rd_idx, bn.rd_data, exp);
      end
    end
    bn.rd_idx = 3'd7;
    step();
    checks++;
    if (bn.rd_data !== 4'h0 || bn.rd_ovf !== 1'b0) begin
      errors++;
      $display("FAIL oor_read rd_data=%0h rd_ovf=%0b expected 0 0", bn.rd_data, bn.rd_ovf);
    end
  endtask

  task automatic test_mid_reset();
    bn.wr_en = 1'b1; bn.wr_idx = 3'd3; bn.wr_data = 4'hF;
    step();
    bn.wr_en = 1'b0; bn.inc = 6'h3F; bn.rd_idx = 3'd3;
    ba.inc = 8'hFF; ba.rd_idx = 3'd2;
    step();
    step();
    checks++;
    if (bn.ovf[3] !== 1'b1 || bn.rd_ovf !== 1'b1 || ba.rd_data !== 32'd101) begin
      errors++;
      $display("FAIL pre_reset ovf3=%0b rd_ovf=%0b a.rd_data=%0d expected 1 1 101",
               bn.ovf[3], bn.rd_ovf, ba.rd_data);
    end
    rst = 1'b1; ba.clr_all = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if (ba.rd_data !== 32'd0 || bn.rd_ovf !== 1'b0 || bn.ovf !== 6'h00 || ba.ovf !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset a.rd=%0d n.rd_ovf=%0b n.ovf=%0h a.ovf=%0h expected 0",
               ba.rd_data, bn.rd_ovf, bn.ovf, ba.ovf);
    end
    step();
    checks++;
    if (ba.rd_data !== 32'd0) begin
      errors++;
      $display("FAIL resume_first rd_data=%0d expected 0", ba.rd_data);
    end
    step();
    checks++;
    if (ba.rd_data !== 32'd1) begin
      errors++;
      $display("FAIL resume_count rd_data=%0d expected 1", ba.rd_data);
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_saturate();
    test_collision();
    test_clr_all();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
